pipe_skid_stage: RTL and testbench

//  Parametrised inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) with valid/ready handshake.

---
 rtl/pipe_skid_stage_pkg.sv | 26 ++
 rtl/pipe_skid_stage_if.sv | 31 +++
 rtl/pipe_skid_stage_slot.sv | 25 ++
 rtl/pipe_skid_stage.sv | 133 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared widths, FSM encoding and entry layout for the skid pipeline stage.
// Included by pipe_skid_stage (optional perf counters under PIPE_SKID_PERF_EN).
package pipe_pkg;

   localparam int CTRL_W = 10;
   localparam int DATA_W = 32;
   localparam int NDATA  = 4;
   localparam int RN_W   = 5;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [CTRL_W-1:0]       ctrl;
      logic [NDATA*DATA_W-1:0] data;
      logic [RN_W-1:0]         rn;
   } pipe_ent_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready bundle between two pipeline stages.
// master = upstream/downstream environment, slave = the stage itself.
interface pipe_skid_stage_if #(
   parameter int CTRL_W = pipe_pkg::CTRL_W,
   parameter int DATA_W = pipe_pkg::DATA_W,
   parameter int NDATA  = pipe_pkg::NDATA,
   parameter int RN_W   = pipe_pkg::RN_W
) ();

   logic                    in_valid;
   logic                    in_ready;
   logic [CTRL_W-1:0]       in_ctrl;
   logic [NDATA*DATA_W-1:0] in_data;
   logic [RN_W-1:0]         in_rn;
   logic                    out_valid;
   logic                    out_ready;
   logic [CTRL_W-1:0]       out_ctrl;
   logic [NDATA*DATA_W-1:0] out_data;
   logic [RN_W-1:0]         out_rn;

   modport master (
      output in_valid, in_ctrl, in_data, in_rn, out_ready,
      input  in_ready, out_valid, out_ctrl, out_data, out_rn
   );

   modport slave (
      input  in_valid, in_ctrl, in_data, in_rn, out_ready,
      output in_ready, out_valid, out_ctrl, out_data, out_rn
   );

endinterface

// File: rtl/pipe_skid_stage_slot.sv
// One entry register of the skid stage: load enable, async clear.
// Used for both the main and the skid slot.
module pipe_slot #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         load_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         q_q <= '0;
      end else if (load_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Inter-stage register with 1-entry skid slot, flush and registered in_ready.
// Define PIPE_SKID_PERF_EN to add saturating stall/bubble counters.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int CTRL_W = pipe_pkg::CTRL_W,
   parameter int DATA_W = pipe_pkg::DATA_W,
   parameter int NDATA  = pipe_pkg::NDATA,
   parameter int RN_W   = pipe_pkg::RN_W
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              flush,
`ifdef PIPE_SKID_PERF_EN
   output logic [31:0]       stall_cnt,
   output logic [31:0]       bubble_cnt,
`endif
   pipe_skid_stage_if.slave  bus
);

   typedef struct packed {
      logic [CTRL_W-1:0]       ctrl;
      logic [NDATA*DATA_W-1:0] data;
      logic [RN_W-1:0]         rn;
   } ent_t;

   localparam int EW = $bits(ent_t);

   state_t state_q, state_d;
   ent_t   in_ent, main_d, main_q, skid_q;
   logic   main_ld, skid_ld, main_from_skid;
   logic   in_fire, out_fire, out_valid;

   assign out_valid = (state_q != ST_EMPTY);
   assign in_fire   = bus.in_valid & bus.in_ready;
   assign out_fire  = out_valid & bus.out_ready;

   assign in_ent.ctrl = bus.in_ctrl;
   assign in_ent.data = bus.in_data;
   assign in_ent.rn   = bus.in_rn;
   assign main_d      = main_from_skid ? skid_q : in_ent;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      skid_ld        = 1'b0;
      main_from_skid = 1'b0;
      unique case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               main_ld = 1'b1;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               main_ld = 1'b1;
            end else if (in_fire) begin
               skid_ld = 1'b1;
               state_d = ST_TWO;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (out_fire) begin
               main_ld        = 1'b1;
               main_from_skid = 1'b1;
               state_d        = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // flush drops everything, including an entry offered this cycle
      if (flush) begin
         state_d = ST_EMPTY;
         main_ld = 1'b0;
         skid_ld = 1'b0;
      end
   end

   pipe_slot #(.W(EW)) u_main (
      .clock  (clock),
      .resetn (resetn),
      .load_i (main_ld),
      .d_i    (main_d),
      .q_o    (main_q)
   );

   pipe_slot #(.W(EW)) u_skid (
      .clock  (clock),
      .resetn (resetn),
      .load_i (skid_ld),
      .d_i    (in_ent),
      .q_o    (skid_q)
   );

   assign bus.in_ready  = (state_q != ST_TWO);
   assign bus.out_valid = out_valid;
   assign bus.out_ctrl  = out_valid ? main_q.ctrl : '0;
   assign bus.out_rn    = out_valid ? main_q.rn : '0;
   assign bus.out_data  = main_q.data;

`ifdef PIPE_SKID_PERF_EN
   logic [31:0] stall_cnt_q, bubble_cnt_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (out_valid && !bus.out_ready) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
         end
         if (!out_valid && bus.out_ready) begin
            bubble_cnt_q <= sat_inc(bubble_cnt_q);
         end
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: order, stall, flush, bubble, reset.
// Perf-counter checks are compiled only with PIPE_SKID_PERF_EN.
module tb_pipe_skid_stage;
   import pipe_pkg::*;

   localparam int EW = CTRL_W + NDATA*DATA_W + RN_W;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   logic flush  = 1'b0;

   always #5 clock = ~clock;

   pipe_skid_stage_if bus ();

`ifdef PIPE_SKID_PERF_EN
   logic [31:0] stall_cnt, bubble_cnt;
`endif

   pipe_skid_stage dut (
      .clock      (clock),
      .resetn     (resetn),
      .flush      (flush),
`ifdef PIPE_SKID_PERF_EN
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt),
`endif
      .bus        (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   logic [EW-1:0] sb[$];

   task automatic chk(input string tag, input logic [159:0] obs,
                      input logic [159:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic offer(input bit v, input int rn);
      bus.in_valid = v;
      bus.in_rn    = RN_W'(rn);
      bus.in_ctrl  = CTRL_W'(rn * 37 + 1);
      for (int k = 0; k < NDATA; k++)
         bus.in_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      offer(1'b0, 0);
      for (int i = 0; i < 10; i++) begin
         if (sb.size() == 0 && !bus.out_valid) break;
         tick();
      end
      chk("drain_sb", 160'(sb.size()), 160'd0);
      chk("drain_ov", 160'(bus.out_valid), 160'd0);
   endtask

   // protocol-level scoreboard, sampled mid-cycle
   always @(negedge clock) begin
      if (!resetn) begin
         sb.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               chk("underflow", 160'd1, 160'd0);
            end else begin
               chk("out_ent", 160'({bus.out_ctrl, bus.out_data, bus.out_rn}),
                   160'(sb.pop_front()));
            end
         end
         if (!bus.out_valid) begin
            chk("bub_ctrl", 160'(bus.out_ctrl), 160'd0);
            chk("bub_rn", 160'(bus.out_rn), 160'd0);
         end
         if (flush) sb.delete();
         else if (bus.in_valid && bus.in_ready)
            sb.push_back({bus.in_ctrl, bus.in_data, bus.in_rn});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
`ifdef PIPE_SKID_PERF_EN
      logic [31:0] b0;
`endif
      bus.out_ready = 1'b0;
      offer(1'b0, 0);
      #1;
      chk("rst_ov", 160'(bus.out_valid), 160'd0);
      chk("rst_ctrl", 160'(bus.out_ctrl), 160'd0);
      chk("rst_rn", 160'(bus.out_rn), 160'd0);
      chk("rst_data", 160'(bus.out_data), 160'd0);
      chk("rst_rdy", 160'(bus.in_ready), 160'd1);
      tick();
      tick();
      resetn = 1'b1;

      // back-to-back streaming
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         offer(1'b1, k);
         tick();
         chk("str_rdy", 160'(bus.in_ready), 160'd1);
         chk("str_ov", 160'(bus.out_valid), 160'd1);
         chk("str_rn", 160'(bus.out_rn), 160'(k));
      end
      offer(1'b0, 0);
      tick();
      chk("str_end", 160'(bus.out_valid), 160'd0);

      // stall into skid slot
      offer(1'b1, 3);
      tick();
      chk("stl_rn3", 160'(bus.out_rn), 160'd3);
      bus.out_ready = 1'b0;
      offer(1'b1, 4);
      tick();
      chk("stl_rdy0", 160'(bus.in_ready), 160'd0);
      chk("stl_hold3", 160'(bus.out_rn), 160'd3);
      offer(1'b1, 5);
      tick();
      chk("stl_rdy0b", 160'(bus.in_ready), 160'd0);
      chk("stl_hold3b", 160'(bus.out_rn), 160'd3);
      bus.out_ready = 1'b1;
      tick();
      chk("stl_rn4", 160'(bus.out_rn), 160'd4);
      chk("stl_rdy1", 160'(bus.in_ready), 160'd1);
      tick();
      chk("stl_rn5", 160'(bus.out_rn), 160'd5);
      offer(1'b0, 0);
      tick();
      chk("stl_end", 160'(bus.out_valid), 160'd0);

      // flush while full, with an entry offered
      bus.out_ready = 1'b0;
      offer(1'b1, 6);
      tick();
      offer(1'b1, 7);
      tick();
      chk("fl_two", 160'(bus.in_ready), 160'd0);
      offer(1'b1, 9);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      offer(1'b0, 0);
      chk("fl_ov", 160'(bus.out_valid), 160'd0);
      chk("fl_ctrl", 160'(bus.out_ctrl), 160'd0);
      chk("fl_rdy", 160'(bus.in_ready), 160'd1);
      bus.out_ready = 1'b1;
      repeat (3) begin
         tick();
         chk("fl_no9", 160'(bus.out_valid), 160'd0);
      end

      // flush in ONE with simultaneous in_fire and out_fire
      offer(1'b1, 20);
      tick();
      offer(1'b1, 21);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      offer(1'b0, 0);
      chk("fl1_ov", 160'(bus.out_valid), 160'd0);
      tick();
      chk("fl1_no21", 160'(bus.out_valid), 160'd0);

      // bubbles
      tick();
`ifdef PIPE_SKID_PERF_EN
      b0 = bubble_cnt;
`endif
      repeat (3) begin
         tick();
         chk("bb_ctrl", 160'(bus.out_ctrl), 160'd0);
         chk("bb_rn", 160'(bus.out_rn), 160'd0);
      end
`ifdef PIPE_SKID_PERF_EN
      chk("bb_cnt", 160'(bubble_cnt), 160'(b0 + 32'd3));

      // stall counter saturation
      bus.out_ready = 1'b0;
      offer(1'b1, 10);
      tick();
      offer(1'b0, 0);
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      repeat (3) tick();
      chk("stl_sat", 160'(stall_cnt), 160'hFFFF_FFFF);
      drain();
`endif

      // async reset mid-stream
      bus.out_ready = 1'b0;
      offer(1'b1, 11);
      tick();
      offer(1'b1, 12);
      tick();
      @(posedge clock);
      #3;
      resetn = 1'b0;
      #1;
      chk("mrst_ov", 160'(bus.out_valid), 160'd0);
      chk("mrst_ctrl", 160'(bus.out_ctrl), 160'd0);
      chk("mrst_rn", 160'(bus.out_rn), 160'd0);
      chk("mrst_rdy", 160'(bus.in_ready), 160'd1);
`ifdef PIPE_SKID_PERF_EN
      chk("mrst_stall", 160'(stall_cnt), 160'd0);
`endif
      offer(1'b0, 0);
      tick();
      resetn = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      tick();
      chk("mrst_nosurv", 160'(bus.out_valid), 160'd0);

      // a final short stream after reset
      for (int k = 13; k <= 15; k++) begin
         offer(1'b1, k);
         tick();
         chk("post_rn", 160'(bus.out_rn), 160'(k));
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
